// File: rtl/cpu_trace_buffer.sv
// Commit-trace and statistics unit for the pipelined cpu core.
// Records REG/LOAD/STORE/HALT events into a circular FWFT buffer.
module cpu_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 32,
  parameter int MAX_CYCLES = 100000,
  parameter bit WRAP       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_we,
  input  logic [3:0]       reg_idx,
  input  logic [15:0]      reg_data,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             hlt,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [37:0]      rd_data,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CYC_W-1:0] inst_count,
  output logic [CYC_W-1:0] drop_count,
  output logic             halted,
  output logic             timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 2;
  localparam logic [CYC_W-1:0] LIM = CYC_W'(MAX_CYCLES - 1);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    TMO
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] inst_q, inst_d;
  logic [CYC_W-1:0] drop_q, drop_d;
  logic [37:0] mem_q [DEPTH];

  logic [37:0] ev [3];
  logic [1:0] p, nwr;
  logic run, pop;
  logic [NW-1:0] n, e;

  always_comb begin
    run = (state_q == RUN);
    pop = rd_en && (count_q != '0);
    p = 2'd0;
    ev[0] = '0;
    ev[1] = '0;
    ev[2] = '0;
    if (run && reg_we) begin
      ev[p] = {2'b00, reg_idx, 16'h0000, reg_data};
      p = p + 2'd1;
    end
    if (run && mem_wr) begin
      ev[p] = {2'b10, 4'h0, mem_addr, mem_wdata};
      p = p + 2'd1;
    end else if (run && mem_rd) begin
      ev[p] = {2'b01, 4'h0, mem_addr, mem_rdata};
      p = p + 2'd1;
    end
    // HALT carries the cycle number it was seen in
    if (run && hlt) begin
      ev[p] = {2'b11, 4'h0, 16'h0000, cyc_q[15:0]};
      p = p + 2'd1;
    end

    n = count_q - NW'(pop) + NW'(p);
    e = (n > FULL) ? n - FULL : '0;
    nwr = WRAP ? p : p - e[1:0];
    count_d = (n > FULL) ? FULL : n;
    rd_ptr_d = rd_ptr_q + AW'(pop) + (WRAP ? AW'(e) : AW'(0));
    wr_ptr_d = wr_ptr_q + AW'(nwr);

    cyc_d = cyc_q;
    inst_d = inst_q;
    state_d = state_q;
    drop_d = drop_q + CYC_W'(e);
    if (run) begin
      cyc_d = cyc_q + 1'b1;
      if (hlt || reg_we || mem_wr)
        inst_d = inst_q + 1'b1;
      if (hlt)
        state_d = HALTED;
      else if (cyc_q == LIM)
        state_d = TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
      inst_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
      inst_q   <= inst_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (i < int'(nwr))
        mem_q[wr_ptr_q + AW'(i)] <= ev[i];
    end
  end

  assign rd_valid    = (count_q != '0);
  assign rd_data     = mem_q[rd_ptr_q];
  assign cycle_count = cyc_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign halted      = (state_q == HALTED);
  assign timeout     = (state_q == TMO);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: four configurations driven in parallel,
// each compared against a queue-based reference model.
module tb_cpu_trace_buffer;

  localparam int NI = 4;
  localparam int PD [NI] = '{4, 4, 8, 16};
  localparam int PW [NI] = '{0, 1, 1, 0};
  localparam int PM [NI] = '{10, 10, 3000, 100000};

  logic clk, rst_n;
  logic reg_we, mem_rd, mem_wr, hlt;
  logic [3:0] reg_idx;
  logic [15:0] reg_data, mem_addr, mem_wdata, mem_rdata;
  logic [NI-1:0] rd_en;

  logic rv [NI];
  logic [37:0] rdd [NI];
  logic [31:0] cc [NI];
  logic [31:0] ic [NI];
  logic [31:0] dc [NI];
  logic hl [NI];
  logic to [NI];

  int n_cmp, n_err;

  logic [37:0] mq [NI][$];
  int mcyc [NI];
  int minst [NI];
  int mdrop [NI];
  int mst [NI];

  cpu_trace_buffer #(.DEPTH(4), .CYC_W(32), .MAX_CYCLES(10), .WRAP(1'b0)) u_k (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_data(reg_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hlt(hlt), .rd_en(rd_en[0]), .rd_valid(rv[0]), .rd_data(rdd[0]),
    .cycle_count(cc[0]), .inst_count(ic[0]), .drop_count(dc[0]),
    .halted(hl[0]), .timeout(to[0])
  );

  cpu_trace_buffer #(.DEPTH(4), .CYC_W(32), .MAX_CYCLES(10), .WRAP(1'b1)) u_w (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_data(reg_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hlt(hlt), .rd_en(rd_en[1]), .rd_valid(rv[1]), .rd_data(rdd[1]),
    .cycle_count(cc[1]), .inst_count(ic[1]), .drop_count(dc[1]),
    .halted(hl[1]), .timeout(to[1])
  );

  cpu_trace_buffer #(.DEPTH(8), .CYC_W(32), .MAX_CYCLES(3000), .WRAP(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_data(reg_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hlt(hlt), .rd_en(rd_en[2]), .rd_valid(rv[2]), .rd_data(rdd[2]),
    .cycle_count(cc[2]), .inst_count(ic[2]), .drop_count(dc[2]),
    .halted(hl[2]), .timeout(to[2])
  );

  cpu_trace_buffer u_d (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_data(reg_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hlt(hlt), .rd_en(rd_en[3]), .rd_valid(rv[3]), .rd_data(rdd[3]),
    .cycle_count(cc[3]), .inst_count(ic[3]), .drop_count(dc[3]),
    .halted(hl[3]), .timeout(to[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      mcyc[k] = 0;
      minst[k] = 0;
      mdrop[k] = 0;
      mst[k] = 0;
    end
  endtask

  // One clock of the reference: events first, then pop, then pushes
  task automatic model_step(input int k);
    logic [37:0] pend [$];
    if (mst[k] == 0) begin
      if (reg_we) pend.push_back({2'b00, reg_idx, 16'h0, reg_data});
      if (mem_wr) pend.push_back({2'b10, 4'h0, mem_addr, mem_wdata});
      else if (mem_rd) pend.push_back({2'b01, 4'h0, mem_addr, mem_rdata});
      if (hlt) pend.push_back({2'b11, 4'h0, 16'h0, 16'(mcyc[k])});
      if (hlt || reg_we || mem_wr) minst[k]++;
      if (hlt) mst[k] = 1;
      else if (mcyc[k] == PM[k] - 1) mst[k] = 2;
      mcyc[k]++;
    end
    if (rd_en[k] && mq[k].size() != 0) void'(mq[k].pop_front());
    foreach (pend[i]) begin
      if (mq[k].size() < PD[k]) mq[k].push_back(pend[i]);
      else begin
        mdrop[k]++;
        if (PW[k] != 0) begin
          void'(mq[k].pop_front());
          mq[k].push_back(pend[i]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.valid", k), 64'(rv[k]), 64'(mq[k].size() != 0));
      if (mq[k].size() != 0)
        chk($sformatf("u%0d.data", k), 64'(rdd[k]), 64'(mq[k][0]));
      chk($sformatf("u%0d.cyc", k), 64'(cc[k]), 64'(mcyc[k]));
      chk($sformatf("u%0d.inst", k), 64'(ic[k]), 64'(minst[k]));
      chk($sformatf("u%0d.drop", k), 64'(dc[k]), 64'(mdrop[k]));
      chk($sformatf("u%0d.halted", k), 64'(hl[k]), 64'(mst[k] == 1));
      chk($sformatf("u%0d.timeout", k), 64'(to[k]), 64'(mst[k] == 2));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
    check_all();
  endtask

  task automatic idle();
    reg_we = 0; mem_rd = 0; mem_wr = 0; hlt = 0;
    reg_idx = '0; reg_data = '0; mem_addr = '0;
    mem_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rd_en = '0;
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst.valid", 64'(rv[k]), 64'd0);
      chk("rst.cyc", 64'(cc[k]), 64'd0);
      chk("rst.inst", 64'(ic[k]), 64'd0);
      chk("rst.drop", 64'(dc[k]), 64'd0);
      chk("rst.flags", 64'({hl[k], to[k]}), 64'd0);
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_in();
    reg_we = ($urandom_range(0, 99) < 50);
    mem_rd = ($urandom_range(0, 99) < 35);
    mem_wr = ($urandom_range(0, 99) < 35);
    hlt = ($urandom_range(0, 249) == 0);
    reg_idx = 4'($urandom);
    reg_data = 16'($urandom);
    mem_addr = 16'($urandom);
    mem_wdata = 16'($urandom);
    mem_rdata = 16'($urandom);
    rd_en = 4'($urandom);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    idle();
    rd_en = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // single REG event, then pop
    reg_we = 1; reg_idx = 4'd3; reg_data = 16'h00A5;
    tick();
    chk("single.valid", 64'(rv[0]), 64'd1);
    chk("single.data", 64'(rdd[0]), 64'({2'b00, 4'd3, 16'h0000, 16'h00A5}));
    chk("single.inst", 64'(ic[0]), 64'd1);
    idle();
    rd_en = '1;
    tick();
    chk("single.popped", 64'(rv[0]), 64'd0);

    // REG + STORE + HALT in one cycle at cycle_count 7
    do_reset();
    repeat (7) tick();
    reg_we = 1; reg_idx = 4'd5; reg_data = 16'hBEEF;
    mem_wr = 1; mem_addr = 16'h0040; mem_wdata = 16'h1234;
    hlt = 1;
    tick();
    idle();
    chk("halt.flag", 64'(hl[0]), 64'd1);
    chk("halt.tmo", 64'(to[0]), 64'd0);
    chk("halt.cyc", 64'(cc[0]), 64'd8);
    chk("halt.inst", 64'(ic[0]), 64'd1);
    chk("halt.e0", 64'(rdd[0]), 64'({2'b00, 4'd5, 16'h0, 16'hBEEF}));
    rd_en = 4'b0001;
    tick();
    chk("halt.e1", 64'(rdd[0]), 64'({2'b10, 4'd0, 16'h0040, 16'h1234}));
    tick();
    chk("halt.e2", 64'(rdd[0]), 64'({2'b11, 4'd0, 16'h0, 16'h0007}));
    tick();
    chk("halt.empty", 64'(rv[0]), 64'd0);
    chk("halt.frozen", 64'(cc[0]), 64'd8);

    // overflow in both modes, then pop+push on a full buffer
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      reg_we = 1; reg_idx = 4'd1; reg_data = 16'(i);
      tick();
    end
    chk("ovf.drop_k", 64'(dc[0]), 64'd2);
    chk("ovf.drop_w", 64'(dc[1]), 64'd2);
    reg_data = 16'd7;
    rd_en = 4'b0011;
    tick();
    idle();
    chk("ovf.pp_drop_k", 64'(dc[0]), 64'd2);
    chk("ovf.pp_drop_w", 64'(dc[1]), 64'd2);
    begin
      logic [15:0] ek [4];
      logic [15:0] ew [4];
      ek = '{16'd2, 16'd3, 16'd4, 16'd7};
      ew = '{16'd4, 16'd5, 16'd6, 16'd7};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ovf.k%0d", i), 64'(rdd[0][15:0]), 64'(ek[i]));
        chk($sformatf("ovf.w%0d", i), 64'(rdd[1][15:0]), 64'(ew[i]));
        tick();
      end
    end
    chk("ovf.k_empty", 64'(rv[0]), 64'd0);
    chk("ovf.w_empty", 64'(rv[1]), 64'd0);

    // timeout at MAX_CYCLES=10
    do_reset();
    repeat (9) tick();
    chk("tmo.early", 64'(to[0]), 64'd0);
    tick();
    chk("tmo.flag", 64'(to[0]), 64'd1);
    chk("tmo.cyc", 64'(cc[0]), 64'd10);
    reg_we = 1; reg_data = 16'h5555;
    tick();
    idle();
    chk("tmo.norec", 64'(rv[0]), 64'd0);
    chk("tmo.frozen", 64'(cc[0]), 64'd10);

    // hlt in the tenth cycle wins over timeout
    do_reset();
    repeat (9) tick();
    hlt = 1;
    tick();
    idle();
    chk("tmo.hlt_flag", 64'(hl[0]), 64'd1);
    chk("tmo.hlt_tmo", 64'(to[0]), 64'd0);

    // three entries buffered, then asynchronous reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      reg_we = 1; reg_data = 16'(i + 100);
      tick();
    end
    idle();
    chk("arst.pre", 64'(rv[0]), 64'd1);
    do_reset();
    tick();

    // randomized segments
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        rand_in();
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
